// File: rtl/pomodoro_sequencer.sv
// Pomodoro work/break sequencer with a BCD mm:ss countdown and a BCD session counter.
// Define POMO_AUTO_ADVANCE_EN to keep the countdown running across phase changes.
module pomodoro_sequencer #(
    parameter int WORK_MIN   = 25,
    parameter int SHORT_MIN  = 5,
    parameter int LONG_MIN   = 15,
    parameter int LONG_EVERY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        btn_skip,
    input  logic        btn_stop,
    output logic [1:0]  phase,
    output logic        running,
    output logic        phase_done,
    output logic [31:0] disp_dat,
    output logic        disp_vld
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WORK      = 2'd1,
        SHORT_BRK = 2'd2,
        LONG_BRK  = 2'd3
    } phase_t;

    localparam logic [15:0] WORK_LOAD  = {4'(WORK_MIN / 10),  4'(WORK_MIN % 10),  8'h00};
    localparam logic [15:0] SHORT_LOAD = {4'(SHORT_MIN / 10), 4'(SHORT_MIN % 10), 8'h00};
    localparam logic [15:0] LONG_LOAD  = {4'(LONG_MIN / 10),  4'(LONG_MIN % 10),  8'h00};
    localparam logic [3:0]  LONG_EVERY_CNT = 4'(LONG_EVERY);

    phase_t       phase_reg;
    logic         running_reg;
    logic         phase_done_reg;
    logic [15:0]  remain_reg;
    logic [15:0]  sess_reg;
    logic [3:0]   lb_reg;
    logic [31:0]  disp_prev_reg;
    logic         disp_vld_reg;
    logic         first_reg;

    function automatic logic [15:0] load_time(input phase_t p);
        logic [15:0] t;
        case (p)
            SHORT_BRK: t = SHORT_LOAD;
            LONG_BRK:  t = LONG_LOAD;
            default:   t = WORK_LOAD;
        endcase
        return t;
    endfunction

    // mm:ss BCD countdown by one second, borrowing through each digit.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mm_t, mm_u, ss_t, ss_u;
        {mm_t, mm_u, ss_t, ss_u} = t;
        if (ss_u != 4'd0) begin
            ss_u = ss_u - 4'd1;
        end else begin
            ss_u = 4'd9;
            if (ss_t != 4'd0) begin
                ss_t = ss_t - 4'd1;
            end else begin
                ss_t = 4'd5;
                if (mm_u != 4'd0) begin
                    mm_u = mm_u - 4'd1;
                end else begin
                    mm_u = 4'd9;
                    mm_t = mm_t - 4'd1;
                end
            end
        end
        return {mm_t, mm_u, ss_t, ss_u};
    endfunction

    // Ripple BCD increment; a carry out of the top digit means 9999, so hold.
    logic [4:0]  sess_carry;
    logic [15:0] sess_inc;
    assign sess_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sess_digit
            logic [3:0] digit;
            assign digit = sess_reg[gi*4 +: 4];
            assign sess_inc[gi*4 +: 4] = !sess_carry[gi] ? digit :
                                         (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            assign sess_carry[gi+1] = sess_carry[gi] && (digit == 4'd9);
        end
    endgenerate

    logic [15:0] remain_dec;
    logic        last_sec;
    logic        long_due;
    logic        exit_running;
    phase_t      skip_phase;
    phase_t      done_phase;

    assign remain_dec = bcd_dec(remain_reg);
    assign last_sec   = (remain_reg == 16'h0001);
    assign long_due   = ((lb_reg + 4'd1) == LONG_EVERY_CNT);
    assign skip_phase = (phase_reg == WORK) ? SHORT_BRK : WORK;
    assign done_phase = (phase_reg == WORK) ? (long_due ? LONG_BRK : SHORT_BRK) : WORK;

`ifdef POMO_AUTO_ADVANCE_EN
    assign exit_running = running_reg;
`else
    assign exit_running = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg      <= IDLE;
            running_reg    <= 1'b0;
            phase_done_reg <= 1'b0;
            remain_reg     <= WORK_LOAD;
            sess_reg       <= 16'h0000;
            lb_reg         <= 4'd0;
        end else begin
            phase_done_reg <= 1'b0;
            if (btn_stop) begin
                phase_reg   <= IDLE;
                running_reg <= 1'b0;
                remain_reg  <= WORK_LOAD;
                lb_reg      <= 4'd0;
            end else if (btn_skip) begin
                if (phase_reg != IDLE) begin
                    phase_reg      <= skip_phase;
                    running_reg    <= exit_running;
                    remain_reg     <= load_time(skip_phase);
                    phase_done_reg <= 1'b1;
                end
            end else if (btn_pause) begin
                if (phase_reg != IDLE) begin
                    running_reg <= !running_reg;
                end
            end else if (btn_start) begin
                if (phase_reg == IDLE) begin
                    phase_reg <= WORK;
                end
                running_reg <= 1'b1;
            end else if (tick && running_reg && phase_reg != IDLE) begin
                if (last_sec) begin
                    // Complete on the 00:01 tick so 00:00 never shows.
                    phase_reg      <= done_phase;
                    running_reg    <= exit_running;
                    remain_reg     <= load_time(done_phase);
                    phase_done_reg <= 1'b1;
                    if (phase_reg == WORK) begin
                        sess_reg <= sess_carry[4] ? sess_reg : sess_inc;
                        lb_reg   <= long_due ? 4'd0 : lb_reg + 4'd1;
                    end
                end else begin
                    remain_reg <= remain_dec;
                end
            end
        end
    end

    // disp_vld trails a display change by one cycle, plus one pulse after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_prev_reg <= {WORK_LOAD, 16'h0000};
            disp_vld_reg  <= 1'b0;
            first_reg     <= 1'b1;
        end else begin
            disp_vld_reg  <= first_reg || (disp_dat != disp_prev_reg);
            disp_prev_reg <= disp_dat;
            first_reg     <= 1'b0;
        end
    end

    assign phase      = phase_reg;
    assign running    = running_reg;
    assign phase_done = phase_done_reg;
    assign disp_dat   = {remain_reg, sess_reg};
    assign disp_vld   = disp_vld_reg;

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// Randomized and directed bench for pomodoro_sequencer against a seconds-based reference model.
module tb_pomodoro_sequencer;

    localparam int W  = 1;
    localparam int S  = 1;
    localparam int L  = 2;
    localparam int LE = 2;
`ifdef POMO_AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_pause = 1'b0;
    logic        btn_skip = 1'b0;
    logic        btn_stop = 1'b0;
    logic [1:0]  phase;
    logic        running;
    logic        phase_done;
    logic [31:0] disp_dat;
    logic        disp_vld;

    always #5 clk = ~clk;

    pomodoro_sequencer #(
        .WORK_MIN(W), .SHORT_MIN(S), .LONG_MIN(L), .LONG_EVERY(LE)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_start(btn_start), .btn_pause(btn_pause),
        .btn_skip(btn_skip), .btn_stop(btn_stop),
        .phase(phase), .running(running), .phase_done(phase_done),
        .disp_dat(disp_dat), .disp_vld(disp_vld)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: remaining time in plain seconds, counters as integers.
    int          m_phase, m_rem, m_sess, m_lb;
    bit          m_run, m_pd, m_vld, m_first;
    logic [31:0] m_cur, m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_disp(input int rem, input int sess);
        int mm, ss;
        mm = rem / 60;
        ss = rem % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                4'(sess / 1000), 4'((sess / 100) % 10), 4'((sess / 10) % 10), 4'(sess % 10)};
    endfunction

    function automatic int dur_sec(input int p);
        return (p == 2 ? S : (p == 3 ? L : W)) * 60;
    endfunction

    task automatic model_exit(input int nxt);
        m_phase = nxt;
        m_rem   = dur_sec(nxt);
        m_pd    = 1'b1;
        if (!AUTO) m_run = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit t, input bit st, input bit pa,
                              input bit sk, input bit sp);
        m_pd = 1'b0;
        if (r) begin
            m_vld = 1'b0; m_first = 1'b1;
            m_phase = 0; m_run = 1'b0; m_rem = W * 60; m_sess = 0; m_lb = 0;
            m_prev = model_disp(W * 60, 0);
        end else begin
            m_vld   = m_first || (m_cur != m_prev);
            m_prev  = m_cur;
            m_first = 1'b0;
            if (sp) begin
                m_phase = 0; m_run = 1'b0; m_rem = W * 60; m_lb = 0;
            end else if (sk) begin
                if (m_phase != 0) model_exit(m_phase == 1 ? 2 : 1);
            end else if (pa) begin
                if (m_phase != 0) m_run = !m_run;
            end else if (st) begin
                if (m_phase == 0) m_phase = 1;
                m_run = 1'b1;
            end else if (t && m_run && m_phase != 0) begin
                if (m_rem > 1) begin
                    m_rem--;
                end else if (m_phase == 1) begin
                    m_sess = (m_sess < 9999) ? m_sess + 1 : 9999;
                    m_lb++;
                    if (m_lb == LE) begin
                        m_lb = 0;
                        model_exit(3);
                    end else begin
                        model_exit(2);
                    end
                end else begin
                    model_exit(1);
                end
            end
        end
        m_cur = model_disp(m_rem, m_sess);
    endtask

    task automatic cycle(input bit r, input bit t, input bit st, input bit pa,
                         input bit sk, input bit sp);
        @(negedge clk);
        rst = r; tick = t; btn_start = st; btn_pause = pa; btn_skip = sk; btn_stop = sp;
        @(posedge clk);
        #1;
        model_step(r, t, st, pa, sk, sp);
        check("phase", 32'(phase), 32'(m_phase));
        check("running", 32'(running), 32'(m_run));
        check("phase_done", 32'(phase_done), 32'(m_pd));
        check("disp_dat", disp_dat, m_cur);
        check("disp_vld", 32'(disp_vld), 32'(m_vld));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0);
    endtask

    task automatic start_btn();
        cycle(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] held;

        // Reset state and the single post-reset disp_vld pulse.
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_disp", disp_dat, 32'h0100_0000);
        check("rst_vld", 32'(disp_vld), 32'd0);
        cycle(0, 0, 0, 0, 0, 0);
        check("post_rst_vld", 32'(disp_vld), 32'd1);
        cycle(0, 1, 0, 1, 1, 0);
        check("idle_ignore", 32'(phase), 32'd0);
        check("post_rst_vld_end", 32'(disp_vld), 32'd0);

        // First WORK phase: 59 ticks leave 00:01, the 60th completes.
        start_btn();
        ticks(59);
        check("w59_phase", 32'(phase), 32'd1);
        check("w59_time", 32'(disp_dat[31:16]), 32'h0001);
        ticks(1);
        check("w60_phase", 32'(phase), 32'd2);
        check("w60_disp", disp_dat, 32'h0100_0001);
        check("w60_done", 32'(phase_done), 32'd1);
        check("w60_run", 32'(running), AUTO ? 32'd1 : 32'd0);
        ticks(3);
        check("brk_ticks", 32'(disp_dat[31:16]), AUTO ? 32'h0057 : 32'h0100);

        // Finish the short break, second WORK -> LONG_BRK, then back to WORK.
        start_btn();
        ticks(AUTO ? 57 : 60);
        check("sb_end_phase", 32'(phase), 32'd1);
        start_btn();
        ticks(60);
        check("long_phase", 32'(phase), 32'd3);
        check("long_disp", disp_dat, 32'h0200_0002);
        start_btn();
        ticks(120);
        check("long_end_phase", 32'(phase), 32'd1);

        // Pause freezes the countdown and display.
        start_btn();
        cycle(0, 0, 0, 1, 0, 0);
        held = disp_dat;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            check("pause_disp", disp_dat, held);
            check("pause_vld", 32'(disp_vld), 32'd0);
        end
        start_btn();
        ticks(1);
        check("resume_dec", 32'(disp_dat[31:16]), 32'h0059);

        // Skip beats a same-cycle tick; stop keeps the session count.
        cycle(0, 1, 0, 0, 1, 0);
        check("skip_phase", 32'(phase), 32'd2);
        check("skip_disp", disp_dat, 32'h0100_0002);
        cycle(0, 1, 1, 1, 1, 1);
        check("stop_phase", 32'(phase), 32'd0);
        check("stop_disp", disp_dat, 32'h0100_0002);
        check("stop_run", 32'(running), 32'd0);

        // Session count saturates at 9999.
        dut.sess_reg = 16'h9999;
        m_sess = 9999;
        m_cur = model_disp(m_rem, m_sess);
        start_btn();
        ticks(60);
        check("sat_sess", 32'(disp_dat[15:0]), 32'h9999);
        check("sat_phase", 32'(phase), 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r, t, st, pa, sk, sp;
            r  = ($urandom_range(0, 599) == 0);
            t  = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 9) == 0);
            pa = ($urandom_range(0, 39) == 0);
            sk = ($urandom_range(0, 79) == 0);
            sp = ($urandom_range(0, 199) == 0);
            cycle(r, t, st, pa, sk, sp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pomodoro_sequencer.md
POMODORO_SEQUENCER -- requirements
Module: pomodoro_sequencer

Interface
REQ-001 Parameter WORK_MIN, default 25, work phase length in minutes (legal range 1..99).
REQ-002 Parameter SHORT_MIN, default 5, short break length in minutes (legal range 1..99).
REQ-003 Parameter LONG_MIN, default 15, long break length in minutes (legal range 1..99).
REQ-004 Parameter LONG_EVERY, default 4, number of completed work phases per long break (legal range 1..15).
REQ-005 Port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port tick, input, 1, one-cycle pulse once per second.
REQ-008 Ports btn_start, btn_pause, btn_skip and btn_stop SHALL each be a 1-bit input carrying a one-cycle edge-detected pulse.
REQ-009 Port phase, output, 2, 0=IDLE, 1=WORK, 2=SHORT_BRK, 3=LONG_BRK.
REQ-010 Port running, output, 1, countdown active.
REQ-011 Port phase_done, output, 1, one-cycle pulse on any phase exit by completion or skip.
REQ-012 Port disp_dat, output, 32, BCD nibbles {mm_t, mm_u, ss_t, ss_u, sess_th, sess_h, sess_t, sess_u}.
REQ-013 Port disp_vld, output, 1, one-cycle pulse whenever disp_dat changes.

Function
REQ-014 Remaining time SHALL be held as four BCD digits mm:ss, and a load SHALL set mm to the BCD value of the phase's *_MIN parameter and ss to 00.
REQ-015 Decrement SHALL be BCD with borrow: ss_u 0->9 borrows; ss_t 0->5 borrows; mm_u 0->9 borrows; mm_t decrements.
REQ-016 Per-cycle event priority SHALL be btn_stop > btn_skip > btn_pause > btn_start > tick, with at most one event acted on per cycle and lower-priority events in that cycle discarded.
REQ-017 btn_stop in any state SHALL go to IDLE with running=0, load WORK_MIN, and clear the long-break counter, while session count is kept.
REQ-018 In IDLE, btn_start SHALL go to WORK with running=1; in IDLE, tick, btn_pause and btn_skip SHALL be ignored.
REQ-019 In an active phase, btn_pause SHALL toggle running.
REQ-020 In an active phase, btn_start SHALL set running=1, and SHALL have no effect if running is already 1.
REQ-021 A tick with running=1 and remaining > 00:01 SHALL decrement remaining by one second.
REQ-022 A tick with running=1 and remaining == 00:01 SHALL complete the phase on that same edge, so that 00:00 is never displayed and a phase lasts exactly *_MIN*60 ticks.
REQ-023 On WORK completion, session count SHALL increment as 4-digit BCD saturating at 9999, and the long-break counter SHALL increment.
REQ-024 On WORK completion, the next phase SHALL be LONG_BRK and the long-break counter SHALL clear if the long-break counter reaches LONG_EVERY; otherwise the next phase SHALL be SHORT_BRK.
REQ-025 On break completion, the next phase SHALL be WORK.
REQ-026 btn_skip in an active phase SHALL exit immediately: WORK goes to SHORT_BRK with neither counter changed, and a break goes to WORK.
REQ-027 Any phase exit SHALL load the next phase's duration on the same edge and SHALL assert phase_done for exactly the following cycle.
REQ-028 disp_vld SHALL be registered and assert in the cycle after disp_dat differs from its prior-cycle value.
REQ-029 phase, running, phase_done, disp_dat and disp_vld SHALL all be registered outputs.

Reset
REQ-030 rst SHALL set phase=IDLE, running=0, remaining=WORK_MIN:00, session count=0, long-break counter=0, phase_done=0.
REQ-031 disp_vld SHALL be 0 during reset and SHALL pulse once in the first cycle after rst deasserts.
REQ-032 rst asserted mid-phase SHALL override all same-cycle events.

Configuration
REQ-033 With macro POMO_AUTO_ADVANCE_EN defined, running SHALL remain 1 across a completion-driven phase change.
REQ-034 Without POMO_AUTO_ADVANCE_EN, every phase exit SHALL clear running, leaving the next phase loaded and waiting for btn_start.
REQ-035 btn_skip SHALL follow the same POMO_AUTO_ADVANCE_EN rule as completion.

Verification (WORK_MIN=1, SHORT_MIN=1, LONG_MIN=2, LONG_EVERY=2, macro defined unless noted)
REQ-036 Reset, then btn_start, then 59 ticks -> phase=1, disp_dat[31:16]=0x0001; the 60th tick -> phase=2, remaining 01:00, sess=0001, phase_done pulse.
REQ-037 Run two full WORK phases -> phase=3 with remaining 02:00 and sess=0002; after 120 ticks -> phase=1.
REQ-038 btn_pause then 10 ticks -> remaining unchanged and no disp_vld; btn_start then 1 tick -> remaining decrements.
REQ-039 In WORK, btn_skip and tick in the same cycle -> phase=2 with remaining 01:00 and sess unchanged; btn_stop -> IDLE with remaining 01:00 and sess kept.
REQ-040 Without the macro, WORK completion -> phase=2, running=0, and ticks ignored until btn_start.
REQ-041 Preload session count 9999 and complete WORK -> count stays 9999.
